// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared types and helpers for the instruction-fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   word_align()  : forces a byte address onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MISS  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// ---------------------------------------------------------------------------
// icache_dm
// Direct-mapped instruction cache, one 32-bit word per line.
// Ports:
//   clk, rst_n   clock / async active-low reset (clears valid bits only)
//   rd_word      word address being looked up (byte address >> 2)
//   rd_hit       line valid and tag matches (combinational)
//   rd_data      line contents (combinational, meaningful only on a hit)
//   wr_en        fill strobe
//   wr_word      word address of the fill
//   wr_data      fill data
// ---------------------------------------------------------------------------
module icache_dm
    import if_fetch_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-3:0]   rd_word,
    output logic                rd_hit,
    output logic [INST_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [ADDR_W-3:0]   wr_word,
    input  logic [INST_W-1:0]   wr_data
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [INST_W-1:0] data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[ADDR_W-3:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[ADDR_W-3:IDX_W];

    // Only the valid bits need a reset; tag/data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage: holds the fetch PC, looks it up in a direct-mapped
// cache, pushes {inst, pc} to the instruction queue on a hit and fetches from
// the memory controller on a miss. Static prediction is pc+4; clr redirects.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | looking up pc; push on hit, start a request on miss
//   ST_MISS  | request outstanding for the current pc
//   ST_DRAIN | request outstanding but pc was redirected; fill still kept
//
// Ports:
//   clk, rst_n         clock / async active-low reset
//   rdy                global enable, 0 freezes all state
//   clr, clr_pc        redirect pulse and target
//   IQ_full            instruction queue full
//   IF_S, IF_Inst, IF_pc  combinational push to the queue
//   MC_req, MC_addr    registered request to the memory controller
//   MC_valid, MC_data  one-cycle response from the memory controller
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                IDX_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_pc,
    input  logic              IQ_full,
    output logic              IF_S,
    output logic [INST_W-1:0] IF_Inst,
    output logic [ADDR_W-1:0] IF_pc,
    output logic              MC_req,
    output logic [ADDR_W-1:0] MC_addr,
    input  logic              MC_valid,
    input  logic [INST_W-1:0] MC_data
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mc_req_q, mc_req_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic              fill_en;
    logic              hit;
    logic [INST_W-1:0] hit_data;

    icache_dm #(.IDX_W(IDX_W)) u_icache (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_word (pc_q[ADDR_W-1:2]),
        .rd_hit  (hit),
        .rd_data (hit_data),
        .wr_en   (fill_en),
        .wr_word (mc_addr_q[ADDR_W-1:2]),
        .wr_data (MC_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        fill_en   = 1'b0;

        // A response seen while rdy=0 is dropped; the controller shares rdy.
        if (rdy) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        pc_d = clr_pc;
                    end else if (hit) begin
                        if (!IQ_full) begin
                            pc_d = pc_q + 32'd4;
                        end
                    end else begin
                        mc_req_d  = 1'b1;
                        mc_addr_d = word_align(pc_q);
                        state_d   = ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (MC_valid) begin
                        fill_en  = 1'b1;
                        mc_req_d = 1'b0;
                        state_d  = ST_IDLE;
                        if (clr) begin
                            pc_d = clr_pc;
                        end
                    end else if (clr) begin
                        // Request cannot be aborted; wait it out in DRAIN.
                        pc_d    = clr_pc;
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Word is still real instruction memory, so fill anyway.
                    if (MC_valid) begin
                        fill_en  = 1'b1;
                        mc_req_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                    if (clr) begin
                        pc_d = clr_pc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign IF_S    = rdy && rst_n && !clr && (state_q == ST_IDLE) && hit && !IQ_full;
    assign IF_Inst = hit_data;
    assign IF_pc   = pc_q;
    assign MC_req  = mc_req_q;
    assign MC_addr = mc_addr_q;

endmodule
